// File: rtl/sobel_mag.sv
// Sobel gradient magnitude stage: two-register valid/ready pipeline computing a
// saturated |gx|+|gy|, an edge flag, a window-fill border mask and a frame-last marker.
module sobel_mag #(
   parameter int WIDTH_P  = 8,
   parameter int DEPTH_P  = 16,
   parameter int HEIGHT_P = 16
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [2*WIDTH_P-1:0]   gx_i,
   input  logic [2*WIDTH_P-1:0]   gy_i,
   input  logic [WIDTH_P-1:0]     thresh_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [WIDTH_P-1:0]     mag_o,
   output logic                   edge_o,
   output logic                   last_o
);

   localparam int GW = 2 * WIDTH_P;
   localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
   localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(DEPTH_P - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT_P - 1);
   localparam logic [GW:0]   MAG_MAX = {{(GW + 1 - WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

   // Handshake: a beat moves on the input when valid_i & ready_o and on the output
   // when valid_o & ready_i at a rising edge; a stage refills only when empty or draining.
   logic            s1_valid_q, s1_valid_d;
   logic [GW-1:0]   s1_ax_q, s1_ax_d;
   logic [GW-1:0]   s1_ay_q, s1_ay_d;
   logic            s1_border_q, s1_border_d;
   logic            s1_last_q, s1_last_d;
   logic            s2_valid_q, s2_valid_d;
   logic [WIDTH_P-1:0] s2_mag_q, s2_mag_d;
   logic            s2_edge_q, s2_edge_d;
   logic            s2_last_q, s2_last_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;

   logic            s2_open;
   logic            in_fire;
   logic [GW:0]     sum;
   logic [WIDTH_P-1:0] mag_sat;

   // The most negative code has no positive twin; clamp it to the largest positive value.
   function automatic logic [GW-1:0] abs_sat(input logic [GW-1:0] g);
      logic [GW-1:0] r;
      if (g == {1'b1, {(GW - 1){1'b0}}}) begin
         r = {1'b0, {(GW - 1){1'b1}}};
      end else if (g[GW-1]) begin
         r = -g;
      end else begin
         r = g;
      end
      return r;
   endfunction

   assign s2_open = ~s2_valid_q | ready_i;
   assign ready_o = ~s1_valid_q | s2_open;
   assign in_fire = valid_i & ready_o;

   assign sum     = {1'b0, s1_ax_q} + {1'b0, s1_ay_q};
   assign mag_sat = (sum > MAG_MAX) ? {WIDTH_P{1'b1}} : sum[WIDTH_P-1:0];

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_ax_d     = s1_ax_q;
      s1_ay_d     = s1_ay_q;
      s1_border_d = s1_border_q;
      s1_last_d   = s1_last_q;
      s2_valid_d  = s2_valid_q;
      s2_mag_d    = s2_mag_q;
      s2_edge_d   = s2_edge_q;
      s2_last_d   = s2_last_q;
      col_d       = col_q;
      row_d       = row_q;

      if (ready_o) begin
         s1_valid_d = in_fire;
      end
      if (in_fire) begin
         s1_ax_d     = abs_sat(gx_i);
         s1_ay_d     = abs_sat(gy_i);
         s1_border_d = ({1'b0, col_q} < (CW + 1)'(2)) || ({1'b0, row_q} < (RW + 1)'(2));
         s1_last_d   = (col_q == COL_MAX) && (row_q == ROW_MAX);
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (s2_open) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_mag_d  = s1_border_q ? '0 : mag_sat;
            s2_edge_d = s1_border_q ? 1'b0 : (mag_sat > thresh_i);
            s2_last_d = s1_last_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_valid_q  <= 1'b0;
         s1_ax_q     <= '0;
         s1_ay_q     <= '0;
         s1_border_q <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_mag_q    <= '0;
         s2_edge_q   <= 1'b0;
         s2_last_q   <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_ax_q     <= s1_ax_d;
         s1_ay_q     <= s1_ay_d;
         s1_border_q <= s1_border_d;
         s1_last_q   <= s1_last_d;
         s2_valid_q  <= s2_valid_d;
         s2_mag_q    <= s2_mag_d;
         s2_edge_q   <= s2_edge_d;
         s2_last_q   <= s2_last_d;
         col_q       <= col_d;
         row_q       <= row_d;
      end
   end

   assign valid_o = s2_valid_q;
   assign mag_o   = s2_mag_q;
   assign edge_o  = s2_edge_q;
   assign last_o  = s2_last_q;

endmodule

// File: tb/tb_sobel_mag.sv
// Bench for sobel_mag on a 4x3 frame: directed frames, saturation and threshold
// corners, random backpressure and a mid-frame reset, checked against a pixel model.
module tb_sobel_mag;

   localparam int W = 8;
   localparam int D = 4;
   localparam int H = 3;

   logic           clk_i = 1'b0;
   logic           rstn_i = 1'b0;
   logic           valid_i = 1'b0;
   logic           ready_o;
   logic [2*W-1:0] gx_i = '0;
   logic [2*W-1:0] gy_i = '0;
   logic [W-1:0]   thresh_i = '0;
   logic           valid_o;
   logic           ready_i = 1'b1;
   logic [W-1:0]   mag_o;
   logic           edge_o;
   logic           last_o;

   sobel_mag #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
      .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i), .valid_o(valid_o),
      .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o), .last_o(last_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Pixel model: plain integer arithmetic from the magnitude/border/threshold rules.
   function automatic int ref_abs(input int g);
      if (g == -32768) return 32767;
      return (g < 0) ? -g : g;
   endfunction

   function automatic int ref_mag(input int gx, input int gy, input bit border);
      int s;
      if (border) return 0;
      s = ref_abs(gx) + ref_abs(gy);
      return (s > 255) ? 255 : s;
   endfunction

   // Scoreboard state
   logic [W+1:0] exp_q[$];
   int           acc_q[$];
   int           m_col = 0;
   int           m_row = 0;
   int           cyc = 0;
   bit           lat_chk = 0;
   bit           bp = 0;
   int           obs_n = 0;
   int           last_cnt = 0;
   int           obs_mag[512];
   int           obs_edge[512];
   int           obs_last[512];
   bit           prev_stall = 0;
   logic [W+1:0] prev_out = '0;

   always @(posedge clk_i) cyc++;

   initial forever begin
      @(posedge clk_i);
      #1;
      ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk_i) begin
      logic [W+1:0] e;
      int a, mg, gx, gy;
      bit bd, ed, ls;
      if (!rstn_i) begin
         exp_q.delete();
         acc_q.delete();
         m_col = 0;
         m_row = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", int'(valid_o), 1);
            chk("stall_hold", int'({mag_o, edge_o, last_o}), int'(prev_out));
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("out_mag", int'(mag_o), int'(e[W+1:2]));
               chk("out_edge", int'(edge_o), int'(e[1]));
               chk("out_last", int'(last_o), int'(e[0]));
               if (lat_chk) chk("latency", cyc - a, 2);
            end
            if (obs_n < 512) begin
               obs_mag[obs_n]  = int'(mag_o);
               obs_edge[obs_n] = int'(edge_o);
               obs_last[obs_n] = int'(last_o);
               obs_n++;
            end
            if (last_o) last_cnt++;
         end
         prev_stall = valid_o && !ready_i;
         prev_out   = {mag_o, edge_o, last_o};
         if (valid_i && ready_o) begin
            gx = int'($signed(gx_i));
            gy = int'($signed(gy_i));
            bd = (m_col < 2) || (m_row < 2);
            mg = ref_mag(gx, gy, bd);
            ed = (mg > int'(thresh_i));
            ls = (m_col == D - 1) && (m_row == H - 1);
            exp_q.push_back({W'(mg), ed, ls});
            acc_q.push_back(cyc);
            if (m_col == D - 1) begin
               m_col = 0;
               m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
      end
   end

   // Driver tasks
   task automatic send(input int gx, input int gy);
      int t;
      valid_i = 1'b1;
      gx_i = 16'(gx);
      gy_i = 16'(gy);
      t = 0;
      @(negedge clk_i);
      while (!ready_o && t < 1000) begin
         @(negedge clk_i);
         t++;
      end
      if (!ready_o) chk("send_timeout", 0, 1);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      gx_i = 16'($urandom);
      gy_i = 16'($urandom);
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk_i);
         #1;
         gx_i = 16'($urandom);
         gy_i = 16'($urandom);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk_i);
         t++;
      end
      chk("drain", exp_q.size(), 0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid_o"}, int'(valid_o), 0);
      chk({tag, "_mag_o"}, int'(mag_o), 0);
      chk({tag, "_edge_o"}, int'(edge_o), 0);
      chk({tag, "_last_o"}, int'(last_o), 0);
      chk({tag, "_ready_o"}, int'(ready_o), 1);
   endtask

   task automatic apply_reset(input string tag);
      @(posedge clk_i);
      #2;
      rstn_i = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      chk({tag, "_ready_after"}, int'(ready_o), 1);
   endtask

   // Ten border pixels with arbitrary gradients, then two interior pixels.
   task automatic frame(input int gx10, input int gy10, input int gx11, input int gy11);
      for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      send(gx10, gy10);
      send(gx11, gy11);
      drain();
   endtask

   initial begin
      int base, lb;
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, lb, gx, gy;

      chk("model_pin_70", ref_mag(30, -40, 0), 70);
      chk("model_pin_sat", ref_mag(200, 100, 0), 255);
      chk("model_pin_minneg", ref_mag(-32768, 0, 0), 255);
      chk("model_pin_border", ref_mag(200, 100, 1), 0);

      apply_reset("rst0");
      thresh_i = 8'd60;

      // Basic stream, full rate
      base = obs_n;
      lb = last_cnt;
      lat_chk = 1;
      repeat (12) send(30, -40);
      drain();
      lat_chk = 0;
      chk("t1_count", obs_n - base, 12);
      for (int i = 0; i < 12; i++) begin
         chk("t1_mag", obs_mag[base + i], (i >= 10) ? 70 : 0);
         chk("t1_edge", obs_edge[base + i], (i >= 10) ? 1 : 0);
         chk("t1_last", obs_last[base + i], (i == 11) ? 1 : 0);
      end
      chk("t1_last_pulses", last_cnt - lb, 1);

      // Saturation
      base = obs_n;
      frame(200, 100, -32768, 0);
      chk("sat_a_mag", obs_mag[base + 10], 255);
      chk("sat_a_edge", obs_edge[base + 10], 1);
      chk("sat_b_mag", obs_mag[base + 11], 255);
      chk("sat_border_mag", obs_mag[base + 9], 0);

      // Threshold boundary
      base = obs_n;
      frame(20, -40, -60, 0);
      chk("th60_mag", obs_mag[base + 10], 60);
      chk("th60_edge_a", obs_edge[base + 10], 0);
      chk("th60_edge_b", obs_edge[base + 11], 0);
      thresh_i = 8'd59;
      base = obs_n;
      frame(20, -40, -60, 0);
      chk("th59_edge_a", obs_edge[base + 10], 1);
      chk("th59_edge_b", obs_edge[base + 11], 1);

      // Random valid and ready over three frames
      thresh_i = 8'd100;
      lb = last_cnt;
      bp = 1;
      for (int i = 0; i < 36; i++) begin
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
         gx = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 1000)) - 500;
         gy = int'($urandom_range(0, 400)) - 200;
         send(gx, gy);
      end
      drain();
      bp = 0;
      @(posedge clk_i);
      #1;
      chk("bp_last_pulses", last_cnt - lb, 3);

      // Reset mid-frame
      thresh_i = 8'd60;
      repeat (5) send(30, -40);
      @(posedge clk_i);
      #2;
      rstn_i = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      base = obs_n;
      lb = last_cnt;
      repeat (12) send(30, -40);
      drain();
      chk("rm_count", obs_n - base, 12);
      chk("rm_mag_r2c2", obs_mag[base + 10], 70);
      chk("rm_last_12th", obs_last[base + 11], 1);
      chk("rm_last_11th", obs_last[base + 10], 0);
      chk("rm_last_pulses", last_cnt - lb, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
